// File: rtl/bcd_scan_counter.sv
// -----------------------------------------------------------------------------
// bcd_scan_counter
//   Four-digit BCD up/down counter fed by debounced push buttons, with a
//   time-multiplexed digit scan that drives a downstream 7-segment decoder.
//
// Parameters
//   CLK_DIV   clock cycles per scan slot (>= 2)
//   DEBOUNCE  cycles a synced button must disagree with its debounced state
//             before that state flips (>= 2)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   btn_up     raw button, increment (active high)
//   btn_down   raw button, decrement (active high, only with BCD_DOWN_EN)
//   btn_clr    raw button, clear to 0000 (active high)
//   w,x,y,z    BCD digit of the selected slot, w = MSB
//   dig_en     one-hot digit enable, bit 0 = ones digit
//   wrap       one-cycle pulse on 9999->0000 (or 0000->9999 when down enabled)
//
// Configuration macro
//   BCD_DOWN_EN  defined: btn_down conditioning and decrement path built.
//                undefined: btn_down ignored, up+down together increments.
// -----------------------------------------------------------------------------

// Per-button conditioning: 2-FF synchronizer, counter debouncer, rising-edge
// press detector. Release never produces a pulse.
module bcd_btn_cond #(
    parameter int DEBOUNCE = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);
    localparam int CW = $clog2(DEBOUNCE);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_db;
    logic          r_db_d;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_db_d  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            if (r_sync2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE - 1)) begin
                // disagreed long enough: accept the new level
                r_db  <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_press = r_db & ~r_db_d;
endmodule

module bcd_scan_counter #(
    parameter int CLK_DIV  = 100000,
    parameter int DEBOUNCE = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_clr,
    output logic       w,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic [3:0] dig_en,
    output logic       wrap
);
`ifdef BCD_DOWN_EN
    localparam int NBTN = 3;
`else
    localparam int NBTN = 2;
`endif
    localparam int PW = $clog2(CLK_DIV);

    // ---------------- button conditioning ----------------
    logic [NBTN-1:0] w_btn_raw;
    logic [NBTN-1:0] w_press;
    logic            w_up;
    logic            w_clr;

`ifdef BCD_DOWN_EN
    assign w_btn_raw = {btn_down, btn_clr, btn_up};
`else
    assign w_btn_raw = {btn_clr, btn_up};
    logic w_unused_down;
    assign w_unused_down = btn_down;
`endif

    for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
        bcd_btn_cond #(.DEBOUNCE(DEBOUNCE)) u_cond (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_btn   (w_btn_raw[gi]),
            .o_press (w_press[gi])
        );
    end

    assign w_up  = w_press[0];
    assign w_clr = w_press[1];

    // ---------------- count datapath ----------------
    logic [3:0][3:0] r_dig;
    logic [3:0][3:0] w_dig_inc;
    logic [3:0][3:0] w_dig_nxt;
    logic            w_inc_wrap;
    logic            w_wrap_nxt;
    logic            r_wrap;

    // Ripple carry: digits at 9 roll to 0 until the first non-9 digit bumps.
    // w_inc_wrap survives the loop only when every digit was 9.
    always_comb begin
        w_dig_inc  = r_dig;
        w_inc_wrap = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (w_inc_wrap) begin
                if (r_dig[i] == 4'd9) begin
                    w_dig_inc[i] = 4'd0;
                end else begin
                    w_dig_inc[i] = r_dig[i] + 4'd1;
                    w_inc_wrap   = 1'b0;
                end
            end
        end
    end

`ifdef BCD_DOWN_EN
    logic            w_dn;
    logic [3:0][3:0] w_dig_dec;
    logic            w_dec_wrap;

    assign w_dn = w_press[2];

    // Ripple borrow: digits at 0 roll to 9 until the first non-zero digit drops.
    always_comb begin
        w_dig_dec  = r_dig;
        w_dec_wrap = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (w_dec_wrap) begin
                if (r_dig[i] == 4'd0) begin
                    w_dig_dec[i] = 4'd9;
                end else begin
                    w_dig_dec[i] = r_dig[i] - 4'd1;
                    w_dec_wrap   = 1'b0;
                end
            end
        end
    end
`endif

    // clr beats everything; up+down cancel when the down path exists
    always_comb begin
        w_dig_nxt  = r_dig;
        w_wrap_nxt = 1'b0;
        if (w_clr) begin
            w_dig_nxt = '0;
`ifdef BCD_DOWN_EN
        end else if (w_up && w_dn) begin
            w_dig_nxt = r_dig;
        end else if (w_up) begin
            w_dig_nxt  = w_dig_inc;
            w_wrap_nxt = w_inc_wrap;
        end else if (w_dn) begin
            w_dig_nxt  = w_dig_dec;
            w_wrap_nxt = w_dec_wrap;
`else
        end else if (w_up) begin
            w_dig_nxt  = w_dig_inc;
            w_wrap_nxt = w_inc_wrap;
`endif
        end
    end

    // ---------------- scan ----------------
    logic [PW-1:0] r_pre;
    logic [1:0]    r_idx;
    logic [1:0]    w_idx_nxt;
    logic          w_pre_tc;
    logic [3:0]    r_bcd;
    logic [3:0]    r_en;

    assign w_pre_tc  = (r_pre == PW'(CLK_DIV - 1));
    assign w_idx_nxt = w_pre_tc ? r_idx + 2'd1 : r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dig  <= '0;
            r_wrap <= 1'b0;
            r_pre  <= '0;
            r_idx  <= 2'd0;
            r_bcd  <= 4'd0;
            r_en   <= 4'b0001;
        end else begin
            r_dig  <= w_dig_nxt;
            r_wrap <= w_wrap_nxt;
            r_pre  <= w_pre_tc ? '0 : r_pre + PW'(1);
            r_idx  <= w_idx_nxt;
            // next-state index and digits, so a count change on the selected
            // digit shows at the same edge and slot changes have no dead cycle
            r_bcd  <= w_dig_nxt[w_idx_nxt];
            r_en   <= 4'b0001 << w_idx_nxt;
        end
    end

    assign {w, x, y, z} = r_bcd;
    assign dig_en       = r_en;
    assign wrap         = r_wrap;
endmodule
